// File: rtl/ascon128a_rate_packer_pkg.sv
// Shared constants and state encoding for the Ascon-128a rate packer.
package ascon128a_pkg;

    localparam int ASCON_RATE_BYTES = 16;
    localparam logic [7:0] ASCON_PAD_BYTE = 8'h80;

    localparam int IN_W   = 32;
    localparam int RATE_W = ASCON_RATE_BYTES * 8;
    localparam int WORDS  = RATE_W / IN_W;

    localparam logic TYPE_AD = 1'b0;
    localparam logic TYPE_PT = 1'b1;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pack_state_t;

endpackage

// File: rtl/ascon128a_rate_packer_if.sv
// Word-stream input and rate-block output handshakes of the rate packer.
interface ascon128a_rate_packer_if;
    import ascon128a_pkg::*;

    logic [IN_W-1:0]   s_data;
    logic [2:0]        s_bytes;
    logic              s_last;
    logic              s_type;
    logic              s_valid;
    logic              s_ready;

    logic [RATE_W-1:0] m_block;
    logic              m_type;
    logic              m_last;
    logic              m_pad_only;
    logic              m_valid;
    logic              m_ready;

    // The master drives words in and takes blocks out; the packer is the slave.
    modport master (
        output s_data, s_bytes, s_last, s_type, s_valid, m_ready,
        input  s_ready, m_block, m_type, m_last, m_pad_only, m_valid
    );

    modport slave (
        input  s_data, s_bytes, s_last, s_type, s_valid, m_ready,
        output s_ready, m_block, m_type, m_last, m_pad_only, m_valid
    );

endinterface

// File: rtl/ascon128a_rate_packer_pad_insert.sv
// Masks a word to its valid bytes and, on the final word, inserts the 10* pad byte.
module ascon_pad_insert
    import ascon128a_pkg::*;
(
    input  logic [IN_W-1:0] word,
    input  logic [2:0]      bytes,
    input  logic            last,
    output logic [IN_W-1:0] padded_word,
    output logic            zero_fill
);

    always_comb begin
        padded_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < bytes)
                padded_word[31-8*b -: 8] = word[31-8*b -: 8];
            else if (3'(b) == bytes && last)
                padded_word[31-8*b -: 8] = ASCON_PAD_BYTE;
        end
    end

    assign zero_fill = last;

endmodule

// File: rtl/ascon128a_rate_packer.sv
// Packs a 32-bit word stream into padded 128-bit Ascon-128a rate blocks.
// Optional running byte counter enabled by defining ASCON_PACK_BYTECNT_EN.
module ascon128a_rate_packer
    import ascon128a_pkg::*;
(
    input  logic CLK,
    input  logic RST,
`ifdef ASCON_PACK_BYTECNT_EN
    output logic [31:0] msg_bytes,
    output logic [0:0]  msg_bytes_vld,
`endif
    ascon128a_rate_packer_if.slave bus
);

    pack_state_t       state, next_state;
    logic [1:0]        wcnt;
    logic [RATE_W-1:0] block_buf, next_buf;
    logic              pending_pad;
    logic              in_xfer, out_xfer, block_done;
    logic [IN_W-1:0]   padded_word;
    logic              zero_fill;

    assign in_xfer    = bus.s_valid & bus.s_ready;
    assign out_xfer   = bus.m_valid & bus.m_ready;
    assign block_done = bus.s_last || (wcnt == 2'd3);

    ascon_pad_insert u_pad (
        .word        (bus.s_data),
        .bytes       (bus.s_bytes),
        .last        (bus.s_last),
        .padded_word (padded_word),
        .zero_fill   (zero_fill)
    );

    // A last word of exactly 4 bytes pushes the pad byte into the following slot.
    always_comb begin
        next_buf = block_buf;
        for (int i = 0; i < WORDS; i++) begin
            if (2'(i) == wcnt)
                next_buf[RATE_W-1-IN_W*i -: IN_W] = padded_word;
            else if (zero_fill && 2'(i) > wcnt)
                next_buf[RATE_W-1-IN_W*i -: IN_W] =
                    (bus.s_bytes == 3'd4 && 2'(i) == wcnt + 2'd1) ? {ASCON_PAD_BYTE, 24'h0} : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= FILL;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL: if (in_xfer && block_done) next_state = EMIT;
            EMIT: if (out_xfer && !pending_pad) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wcnt           <= '0;
            block_buf      <= '0;
            pending_pad    <= 1'b0;
            bus.m_last     <= 1'b0;
            bus.m_pad_only <= 1'b0;
            bus.m_type     <= 1'b0;
        end else if (in_xfer) begin
            block_buf <= next_buf;
            if (wcnt == 2'd0) bus.m_type <= bus.s_type;
            if (!block_done) wcnt <= wcnt + 2'd1;
            if (bus.s_last && !(wcnt == 2'd3 && bus.s_bytes == 3'd4)) begin
                bus.m_last     <= 1'b1;
                bus.m_pad_only <= (wcnt == 2'd0) && (bus.s_bytes == 3'd0);
            end else begin
                bus.m_last     <= 1'b0;
                bus.m_pad_only <= 1'b0;
                pending_pad    <= bus.s_last;
            end
        end else if (out_xfer) begin
            if (pending_pad) begin
                block_buf      <= {ASCON_PAD_BYTE, {(RATE_W-8){1'b0}}};
                bus.m_last     <= 1'b1;
                bus.m_pad_only <= 1'b1;
                pending_pad    <= 1'b0;
            end else begin
                wcnt <= '0;
            end
        end
    end

    assign bus.s_ready = (state == FILL);
    assign bus.m_valid = (state == EMIT);
    assign bus.m_block = block_buf;

`ifdef ASCON_PACK_BYTECNT_EN
    logic [32:0] byte_sum;
    assign byte_sum = {1'b0, msg_bytes} + {30'b0, bus.s_bytes};

    always_ff @(posedge CLK) begin
        if (RST)
            msg_bytes <= '0;
        else if (out_xfer && bus.m_last)
            msg_bytes <= '0;
        else if (in_xfer)
            msg_bytes <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
    end

    assign msg_bytes_vld = bus.m_valid & bus.m_last;
`endif

    assert property (@(posedge CLK) disable iff (RST)
        bus.s_valid |-> (bus.s_bytes <= 3'd4 && (bus.s_last || bus.s_bytes != 3'd0)));

endmodule

// File: tb/tb_ascon128a_rate_packer.sv
// Directed table-driven bench for ascon128a_rate_packer (optionally with ASCON_PACK_BYTECNT_EN).
module tb_ascon128a_rate_packer;
    import ascon128a_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    ascon128a_rate_packer_if bus ();

`ifdef ASCON_PACK_BYTECNT_EN
    logic [31:0] msg_bytes;
    logic [0:0]  msg_bytes_vld;
`endif

    ascon128a_rate_packer dut (
        .CLK (CLK),
        .RST (RST),
`ifdef ASCON_PACK_BYTECNT_EN
        .msg_bytes     (msg_bytes),
        .msg_bytes_vld (msg_bytes_vld),
`endif
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit           has_word;
        logic [31:0]  data;
        logic [2:0]   bytes;
        logic         last;
        logic         typ;
        bit           has_block;
        logic [127:0] blk;
        logic         blast;
        logic         bpad;
        logic         btyp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit hw, input logic [31:0] d, input logic [2:0] b, input logic l,
                          input logic t, input bit hb, input logic [127:0] blk, input logic bl,
                          input logic bp, input logic bt, input string nm);
        vec_t v;
        v.has_word = hw; v.data = d; v.bytes = b; v.last = l; v.typ = t;
        v.has_block = hb; v.blk = blk; v.blast = bl; v.bpad = bp; v.btyp = bt; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic checkField(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [2:0] b, input logic l, input logic t);
        int waited = 0;
        @(negedge CLK);
        while (!bus.s_ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!bus.s_ready) checkField("s_ready_timeout", 128'(bus.s_ready), 128'd1);
        bus.s_data = d; bus.s_bytes = b; bus.s_last = l; bus.s_type = t; bus.s_valid = 1'b1;
        @(posedge CLK);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic checkOutput(input string nm, input logic [127:0] blk, input logic bl,
                               input logic bp, input logic bt);
        int waited = 0;
        @(negedge CLK);
        while (!bus.m_valid && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        checkField({nm, "_valid"}, 128'(bus.m_valid), 128'd1);
        checkField({nm, "_block"}, bus.m_block, blk);
        checkField({nm, "_last"}, 128'(bus.m_last), 128'(bl));
        checkField({nm, "_pad_only"}, 128'(bus.m_pad_only), 128'(bp));
        checkField({nm, "_type"}, 128'(bus.m_type), 128'(bt));
        bus.m_ready = 1'b1;
        @(posedge CLK);
        #1 bus.m_ready = 1'b0;
    endtask

    initial begin
        bus.s_data = '0; bus.s_bytes = '0; bus.s_last = 1'b0; bus.s_type = 1'b0;
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;

        addVec(1, 32'h00010203, 3'd4, 0, TYPE_PT, 0, '0, 0, 0, 0, "full_w0");
        addVec(1, 32'h04050607, 3'd4, 0, TYPE_PT, 0, '0, 0, 0, 0, "full_w1");
        addVec(1, 32'h08090A0B, 3'd4, 0, TYPE_PT, 0, '0, 0, 0, 0, "full_w2");
        addVec(1, 32'h0C0D0E0F, 3'd4, 1, TYPE_PT, 1, 128'h000102030405060708090A0B0C0D0E0F, 0, 0, 1, "full_blk");
        addVec(0, '0, 3'd0, 0, 0, 1, 128'h80000000000000000000000000000000, 1, 1, 1, "full_pad");
        addVec(1, 32'h11223344, 3'd4, 0, TYPE_AD, 0, '0, 0, 0, 0, "ad_w0");
        addVec(1, 32'hAABB0000, 3'd2, 1, TYPE_AD, 1, 128'h11223344AABB80000000000000000000, 1, 0, 0, "ad_blk");
        addVec(1, 32'h00000000, 3'd0, 1, TYPE_PT, 1, 128'h80000000000000000000000000000000, 1, 1, 1, "empty_pt");
        addVec(1, 32'hDEADBEEF, 3'd4, 0, TYPE_AD, 0, '0, 0, 0, 0, "w4last_w0");
        addVec(1, 32'hCAFEBABE, 3'd4, 0, TYPE_AD, 0, '0, 0, 0, 0, "w4last_w1");
        addVec(1, 32'h01020304, 3'd4, 1, TYPE_AD, 1, 128'hDEADBEEFCAFEBABE0102030480000000, 1, 0, 0, "w4last_blk");
        addVec(1, 32'hA0A1A2A3, 3'd4, 0, TYPE_PT, 0, '0, 0, 0, 0, "b15_w0");
        addVec(1, 32'hB0B1B2B3, 3'd4, 0, TYPE_PT, 0, '0, 0, 0, 0, "b15_w1");
        addVec(1, 32'hC0C1C2C3, 3'd4, 0, TYPE_PT, 0, '0, 0, 0, 0, "b15_w2");
        addVec(1, 32'hD0D1D2FF, 3'd3, 1, TYPE_PT, 1, 128'hA0A1A2A3B0B1B2B3C0C1C2C3D0D1D280, 1, 0, 1, "b15_blk");

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkField("reset_s_ready", 128'(bus.s_ready), 128'd1);
        checkField("reset_m_valid", 128'(bus.m_valid), 128'd0);
        checkField("reset_block", bus.m_block, 128'd0);
        checkField("reset_flags", 128'({bus.m_last, bus.m_pad_only, bus.m_type}), 128'd0);

        foreach (vecs[k]) begin
            if (vecs[k].has_word)
                applyStimulus(vecs[k].data, vecs[k].bytes, vecs[k].last, vecs[k].typ);
            if (vecs[k].has_block)
                checkOutput(vecs[k].name, vecs[k].blk, vecs[k].blast, vecs[k].bpad, vecs[k].btyp);
        end

        // Back-pressure: hold a word pending while the emitted block stalls for 10 cycles.
        applyStimulus(32'h10111213, 3'd4, 0, TYPE_PT);
        applyStimulus(32'h14151617, 3'd4, 0, TYPE_PT);
        applyStimulus(32'h18191A1B, 3'd4, 0, TYPE_PT);
        applyStimulus(32'h1C1D1E1F, 3'd4, 0, TYPE_PT);
        bus.s_data = 32'h77777777; bus.s_bytes = 3'd4; bus.s_last = 1'b0; bus.s_type = TYPE_PT;
        bus.s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            checkField("stall_hold", {bus.m_valid, bus.s_ready, bus.m_block[125:0]},
                       {1'b1, 1'b0, 126'h101112131415161718191A1B1C1D1E1F});
        end
        bus.m_ready = 1'b1;
        @(posedge CLK);
        #1 bus.m_ready = 1'b0;
        @(negedge CLK);
        checkField("stall_release_ready", 128'({bus.s_ready, bus.m_valid}), 128'b10);
        @(posedge CLK);
        #1 bus.s_valid = 1'b0;
        applyStimulus(32'h88888888, 3'd4, 0, TYPE_PT);
        applyStimulus(32'h99999999, 3'd4, 0, TYPE_PT);
        applyStimulus(32'hAAAA0000, 3'd2, 1, TYPE_PT);
        checkOutput("stall_next", 128'h777777778888888899999999AAAA8000, 1, 0, 1);

        // Mid-block reset discards the partial block; idle m_ready must be ignored.
        applyStimulus(32'hEEEEEEEE, 3'd4, 0, TYPE_PT);
        applyStimulus(32'hFFFFFFFF, 3'd4, 0, TYPE_PT);
        @(negedge CLK);
        RST = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkField("rst_mid_idle", 128'({bus.m_valid, bus.s_ready}), 128'b01);
        bus.m_ready = 1'b0;
        applyStimulus(32'h5A000000, 3'd1, 1, TYPE_AD);
        checkOutput("rst_one_byte", 128'h5A800000000000000000000000000000, 1, 0, 0);

`ifdef ASCON_PACK_BYTECNT_EN
        applyStimulus(32'h31323334, 3'd4, 0, TYPE_AD);
        applyStimulus(32'h35363738, 3'd4, 0, TYPE_AD);
        applyStimulus(32'h393A3B3C, 3'd4, 0, TYPE_AD);
        applyStimulus(32'h3D3E3F40, 3'd4, 0, TYPE_AD);
        @(negedge CLK);
        checkField("cnt_first_block", 128'({msg_bytes, msg_bytes_vld}), 128'({32'd16, 1'b0}));
        checkOutput("cnt_blk0", 128'h3132333435363738393A3B3C3D3E3F40, 0, 0, 0);
        applyStimulus(32'h41424344, 3'd4, 1, TYPE_AD);
        @(negedge CLK);
        checkField("cnt_last_block", 128'({msg_bytes, msg_bytes_vld}), 128'({32'd20, 1'b1}));
        checkOutput("cnt_blk1", 128'h41424344800000000000000000000000, 1, 0, 0);
        @(negedge CLK);
        checkField("cnt_cleared", 128'({msg_bytes, msg_bytes_vld}), 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ascon128a_rate_packer.md
Name: ascon128a_rate_packer

Overview:
- Upstream feeder for the Ascon-128a encrypt core. Accepts a 32-bit word stream of associated data or plaintext with a valid/ready handshake.
- Assembles the stream into 128-bit rate blocks and applies Ascon 10* padding (0x80 then zeros).
- Presents each block with last/pad flags to the core's A/P block input.
- One block buffer. No reordering.

Parameters:
- IN_W, 32, input word width in bits. Only 32 is supported.
- RATE_W, 128, rate block width in bits. WORDS = RATE_W/IN_W = 4.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- s_data  in  32  input word; first byte in bits [31:24]
- s_bytes  in  3  valid bytes in s_data, range 0..4; must be 4 unless s_last=1
- s_last  in  1  final word of the current message
- s_type  in  1  0 = associated data, 1 = plaintext; held constant within a message
- s_valid  in  1  input word valid
- s_ready  out  1  packer can accept a word
- m_block  out  128  rate block; first byte in bits [127:120]
- m_type  out  1  s_type of the message this block belongs to
- m_last  out  1  final (padded) block of the message
- m_pad_only  out  1  block holds only padding (0x80 followed by 15 zero bytes)
- m_valid  out  1  block valid
- m_ready  in  1  core accepts the block

Behaviour:
- Transfers: input transfer = s_valid & s_ready; output transfer = m_valid & m_ready. Both happen on a CLK rising edge.
- Reset: RST=1 at an edge forces state FILL and clears word count wcnt, block buffer, m_valid, m_last, m_pad_only and m_type to 0. Any partial block is discarded and no output is produced for it.
- State machine, with s_ready = (state==FILL):
- FILL:
  - An input word is written into buffer slot wcnt (slot 0 = bits [127:96]). Valid bytes are placed MSB-first.
  - Not last, wcnt<3: wcnt+1.
  - Not last, wcnt==3: go to EMIT with last=0, pad_only=0.
  - s_last, bytes at or after total byte offset 4*wcnt+s_bytes < 16: that byte is set to 0x80 and all later bytes to 0. Go to EMIT with last=1. pad_only=1 only if wcnt==0 and s_bytes==0.
  - s_last, wcnt==3, s_bytes==4 (block exactly full): go to EMIT with last=0 and set the pending_pad flag.
- EMIT:
  - m_valid=1. m_block, m_type, m_last and m_pad_only are held stable until the output transfer.
  - On transfer: if pending_pad, load 0x80000...0 with last=1, pad_only=1, clear pending_pad and stay in EMIT. Otherwise wcnt=0 and go to FILL.
- Latency: the block appears with m_valid on the cycle after the input word that completes it. The block buffer is registered.
- Throughput: at best 4 input words then 1 emit cycle (5 cycles per block) with m_ready held high. No input acceptance overlaps EMIT.
- Empty message: a single word with s_last=1, s_bytes=0 gives one pad_only block with last=1.
- s_bytes=0 with s_last=0 is illegal. s_bytes>4 is illegal. Behaviour for either is undefined, and an assertion fires.
- m_ready asserted while m_valid=0 has no effect.
- m_type is latched on the first word of each block.

Optional Feature:
- Macro ASCON_PACK_BYTECNT_EN.
- Defined:
  - Adds output msg_bytes [31:0]: running count of message bytes accepted (excluding padding).
  - msg_bytes clears on RST and on the output transfer of an m_last block. It saturates at 0xFFFFFFFF.
  - Adds output msg_bytes_vld [0:0], equal to m_valid & m_last.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package ascon128a_pkg holds:
  - constants ASCON_RATE_BYTES=16 and ASCON_PAD_BYTE=8'h80;
  - state encoding FILL/EMIT;
  - type constants TYPE_AD=0, TYPE_PT=1.
- One sub-module, ascon_pad_insert: combinational; takes word, byte count and last, and returns the padded word plus the zero-fill enable.

Test Plan:
- 4 full PT words 00010203,04050607,08090A0B,0C0D0E0F with last on the 4th -> block 000102030405060708090A0B0C0D0E0F last=0, then block 80000000000000000000000000000000 last=1 pad_only=1.
- AD words 11223344, AABB with s_bytes=2 and last -> single block 11223344AABB80000000000000000000, last=1, m_type=0.
- Empty PT (s_bytes=0, last) -> block 8000...0 with last=1, pad_only=1, m_type=1.
- m_ready held low 10 cycles during EMIT -> m_block stable, s_ready=0 and no input is consumed; on release the next word is accepted one cycle later.
- RST pulsed after 2 words of a block -> no output; a following 1-byte message 0x5A (s_data=5A000000, s_bytes=1, last) gives block 5A800000000000000000000000000000, last=1.
- With ASCON_PACK_BYTECNT_EN, a 20-byte message -> msg_bytes=20 while the last block is valid, and 0 after its transfer.
